// File: rtl/triangle_height_solver.sv
// Height = 2*area / base by 11-step restoring division on D = {area_q, area_r[0]}.
// Optional range_err output enabled by TRIANGLE_HEIGHT_RANGE_CHECK_EN.
module triangle_height_solver (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  area_q,
    input  logic [1:0]  area_r,
    input  logic [4:0]  base,
    output logic        ready,
    output logic        done,
    output logic [10:0] height_q,
    output logic [4:0]  height_r,
    output logic        div_zero
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    localparam int unsigned DW = 11;
    localparam int unsigned BW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   dividend;
    logic [BW-1:0]   divisor;
    logic [BW-1:0]   part;
    logic [DW-2:0]   quo;
    logic [3:0]      cnt;
    logic            zero_pend;

    logic [BW:0]     shifted;
    logic            fits;
    logic [BW-1:0]   rem_next;
    logic [DW-1:0]   quo_next;
    logic            unused_bits;

    assign unused_bits = area_r[1];

    // One restoring-division step; the remainder always stays below the divisor.
    always_comb begin
        shifted  = {part, dividend[cnt]};
        fits     = 1'b0;
        rem_next = shifted[BW-1:0];
        if (shifted >= {1'b0, divisor}) begin
            fits     = 1'b1;
            rem_next = BW'(shifted - {1'b0, divisor});
        end
        quo_next = {quo, fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            height_q  <= '0;
            height_r  <= '0;
            div_zero  <= 1'b0;
            dividend  <= '0;
            divisor   <= '0;
            part      <= '0;
            quo       <= '0;
            cnt       <= '0;
            zero_pend <= 1'b0;
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dividend  <= {area_q, area_r[0]};
                        divisor   <= base;
                        done      <= 1'b0;
                        div_zero  <= 1'b0;
                        height_q  <= '0;
                        height_r  <= '0;
                        part      <= '0;
                        quo       <= '0;
                        cnt       <= 4'd10;
                        zero_pend <= 1'b0;
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
                        range_err <= 1'b0;
`endif
                        if (base == 5'd0) begin
                            // Zero divisor: result is published one edge later.
                            state     <= DONE;
                            zero_pend <= 1'b1;
                        end else begin
                            state <= DIV;
                            ready <= 1'b0;
                        end
                    end else if (zero_pend) begin
                        zero_pend <= 1'b0;
                        done      <= 1'b1;
                        height_q  <= 11'h7FF;
                        height_r  <= '0;
                        div_zero  <= 1'b1;
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
                        range_err <= 1'b1;
`endif
                    end
                end
                DIV: begin
                    part <= rem_next;
                    quo  <= quo_next[DW-2:0];
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        state    <= DONE;
                        ready    <= 1'b1;
                        done     <= 1'b1;
                        height_q <= quo_next;
                        height_r <= rem_next;
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
                        range_err <= (quo_next > 11'd31) || (rem_next != 5'd0);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_height_solver.sv
// Self-checking bench for triangle_height_solver: vector table, scoreboard queue, corner sequences.
// Also checks range_err when TRIANGLE_HEIGHT_RANGE_CHECK_EN is defined.
module tb_triangle_height_solver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  area_q;
    logic [1:0]  area_r;
    logic [4:0]  base;
    logic        ready;
    logic        done;
    logic [10:0] height_q;
    logic [4:0]  height_r;
    logic        div_zero;
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
    logic        range_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int aq;
        int ar;
        int b;
        int q;
        int r;
        int dz;
        int re;
    } vec_t;

    typedef struct {
        int q;
        int r;
        int dz;
        int re;
        int lat;
        int d;
        int b;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    triangle_height_solver dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .area_q   (area_q),
        .area_r   (area_r),
        .base     (base),
        .ready    (ready),
        .done     (done),
        .height_q (height_q),
        .height_r (height_r),
        .div_zero (div_zero)
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
        ,
        .range_err(range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model, independent of the RTL's bit-serial algorithm.
    function automatic exp_t model(input int aq, input int ar, input int b);
        exp_t e;
        e.d = aq * 2 + (ar & 1);
        e.b = b;
        if (b == 0) begin
            e.q = 2047; e.r = 0; e.dz = 1; e.re = 1; e.lat = 1;
        end else begin
            e.q = e.d / b; e.r = e.d % b; e.dz = 0; e.lat = 11;
            e.re = ((e.q > 31) || (e.r != 0)) ? 1 : 0;
        end
        return e;
    endfunction

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.d = v.aq * 2 + (v.ar & 1);
        e.b = v.b;
        e.q = v.q; e.r = v.r; e.dz = v.dz; e.re = v.re;
        e.lat = (v.b == 0) ? 1 : 11;
        return e;
    endfunction

    task automatic issue(input int aq, input int ar, input int b, input exp_t e, input bit hold);
        @(negedge clk);
        area_q = 10'(aq);
        area_r = 2'(ar);
        base   = 5'(b);
        start  = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Entered at the negedge after the accepting edge; optional mid-operation start pulse or reset.
    task automatic wait_done(input int inject_at, input int rst_at);
        int rdy_low;
        int lat;
        bit seen;
        exp_t e;
        chk("done_cleared_on_accept", int'(done), 0);
        rdy_low = ready ? 0 : 1;
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == inject_at) begin
                start  = 1'b1;
                area_q = 10'd999;
                area_r = 2'd1;
                base   = 5'd7;
            end
            if (k == rst_at) begin
                rst   = 1'b1;
                start = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (k == inject_at) start = 1'b0;
            if (k == rst_at) begin
                rst   = 1'b0;
                start = 1'b0;
                chk("rst_mid_div_done", int'(done), 0);
                chk("rst_mid_div_ready", int'(ready), 1);
                chk("rst_mid_div_hq", int'(height_q), 0);
                chk("rst_mid_div_hr", int'(height_r), 0);
                chk("rst_mid_div_dz", int'(div_zero), 0);
                void'(sb.pop_front());
                return;
            end
            if (!ready) rdy_low++;
            if (done) begin
                seen = 1'b1;
                lat = k;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("height_q", int'(height_q), e.q);
        chk("height_r", int'(height_r), e.r);
        chk("div_zero", int'(div_zero), e.dz);
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
        chk("range_err", int'(range_err), e.re);
`endif
        chk("latency", lat, e.lat);
        chk("ready_low_cycles", rdy_low, (e.lat == 11) ? 11 : 0);
        if (!div_zero) begin
            chk("invariant_sum", int'(height_q) * e.b + int'(height_r), e.d);
            chk("invariant_rem_lt_base", (int'(height_r) < e.b) ? 1 : 0, 1);
        end
    endtask

    initial begin
        exp_t e;
        int aq, ar, b;
        int hq_hold, hr_hold;

        vecs[0] = '{aq: 6,    ar: 0, b: 4,  q: 3,    r: 0, dz: 0, re: 0};
        vecs[1] = '{aq: 7,    ar: 1, b: 3,  q: 5,    r: 0, dz: 0, re: 0};
        vecs[2] = '{aq: 10,   ar: 0, b: 3,  q: 6,    r: 2, dz: 0, re: 1};
        vecs[3] = '{aq: 1023, ar: 1, b: 1,  q: 2047, r: 0, dz: 0, re: 1};
        vecs[4] = '{aq: 5,    ar: 0, b: 0,  q: 2047, r: 0, dz: 1, re: 1};
        vecs[5] = '{aq: 0,    ar: 0, b: 7,  q: 0,    r: 0, dz: 0, re: 0};
        vecs[6] = '{aq: 15,   ar: 1, b: 31, q: 1,    r: 0, dz: 0, re: 0};
        vecs[7] = '{aq: 1023, ar: 1, b: 31, q: 66,   r: 1, dz: 0, re: 1};
        vecs[8] = '{aq: 2,    ar: 3, b: 5,  q: 1,    r: 0, dz: 0, re: 0};

        rst = 1'b1; start = 1'b0; area_q = '0; area_r = '0; base = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_hq", int'(height_q), 0);
        chk("reset_hr", int'(height_r), 0);
        chk("reset_dz", int'(div_zero), 0);
`ifdef TRIANGLE_HEIGHT_RANGE_CHECK_EN
        chk("reset_range_err", int'(range_err), 0);
`endif

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].aq, vecs[i].ar, vecs[i].b, from_vec(vecs[i]), 1'b0);
            wait_done(0, 0);
        end

        // Result held in DONE with no start.
        hq_hold = int'(height_q);
        hr_hold = int'(height_r);
        repeat (3) @(negedge clk);
        chk("hold_done", int'(done), 1);
        chk("hold_hq", int'(height_q), hq_hold);
        chk("hold_hr", int'(height_r), hr_hold);

        // Start pulse with new operands mid-division is ignored.
        issue(7, 1, 3, model(7, 1, 3), 1'b0);
        wait_done(4, 0);

        // Start held from before DONE: new operation accepted on the first DONE edge.
        issue(10, 0, 3, model(10, 0, 3), 1'b1);
        wait_done(0, 0);
        area_q = 10'd6; area_r = 2'd0; base = 5'd4;
        @(posedge clk);
        sb.push_back(model(6, 0, 4));
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 0);

        // Reset during division, then a fresh operation.
        issue(1023, 1, 1, model(1023, 1, 1), 1'b0);
        wait_done(0, 5);
        issue(2, 1, 5, model(2, 1, 5), 1'b0);
        wait_done(0, 0);

        for (int i = 0; i < 8; i++) begin
            aq = int'($urandom_range(1023, 0));
            ar = int'($urandom_range(3, 0));
            b  = (i == 3) ? 0 : int'($urandom_range(31, 1));
            issue(aq, ar, b, model(aq, ar, b), 1'b0);
            wait_done(0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_height_solver.md
# triangle_height_solver

Sequential inverse of the calculator's triangle-area unit: given an area in the area unit's quotient/remainder form (QArea, RArea, where area = QArea + RArea/2) and a known base, computes the height = 2·area / base. It uses an 11-iteration restoring divider. The block sits beside the area unit on the calculator datapath and is driven by the operation sequencer through a start/done handshake.

## Interface
- No parameters; all widths fixed to match the area unit (5-bit operands, 10-bit area quotient, 2-bit area remainder).
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted when ready=1
- area_q  input  10  area integer part (QArea format)
- area_r  input  2  area half-unit remainder (RArea format); bit0 used, bit1 ignored
- base  input  5  known side (divisor)
- ready  output  1  high when a start will be accepted
- done  output  1  result valid, held until next accepted start or reset
- height_q  output  11  quotient of (2·area_q + area_r[0]) / base
- height_r  output  5  remainder of the same division
- div_zero  output  1  base was zero for the current result

## Operation
- States: IDLE, DIV, DONE. Reset → IDLE; all outputs 0 except ready=1.
- ready = (state != DIV).
- Accept (start & ready, in IDLE or DONE): latch dividend D = {area_q, area_r[0]} (11 bits, 0..2047) and base. Clear done, div_zero, height_q, height_r. Then:
  - base = 0: go to DONE next edge with height_q=11'h7FF, height_r=0, div_zero=1.
  - otherwise: go to DIV with bit counter = 10.
- DIV, one edge per dividend bit, MSB first. Partial remainder P (6 bits) := {P[4:0], D[cnt]}.
  - If P ≥ base: P -= base and quotient bit = 1; else quotient bit = 0.
  - Counter decrements; after the cnt=0 iteration, go to DONE.
  - Register height_q and height_r, and set done=1.
- DONE: outputs held stable. start accepted as in IDLE (back-to-back operation). Without start, remain in DONE.
- start while in DIV is ignored; latched operands are not disturbed.
- Input changes outside the accepting edge have no effect.
- Invariant, checked by the bench: height_q·base + height_r == D, and height_r < base, whenever done=1 and div_zero=0.

## Timing
- Latency, non-zero base: start accepted on edge N; done=1 after edge N+11; results valid in that same cycle.
- Latency, base=0: done=1 after edge N+1.
- done falls after the accepting edge of the next start. The new result appears after that operation's latency.
- Throughput: one division per 11 cycles, plus 0 idle cycles when start is held from DONE.
- rst during DIV or DONE: after that edge, state=IDLE and all outputs are at reset values. A start on the same edge as rst is ignored.

## Configuration
- Macro: TRIANGLE_HEIGHT_RANGE_CHECK_EN.
- When defined:
  - Adds output range_err (1 bit), registered together with done.
  - range_err=1 when div_zero=1, height_q > 31, or height_r != 0, i.e. no exact 5-bit integer height exists.
  - range_err resets to 0 and clears on an accepted start.
- When undefined: no range_err port and no associated logic; all other behaviour is identical.

## Test plan
- area_q=6, area_r=0, base=4 → D=12; after 11 cycles done=1, height_q=3, height_r=0, div_zero=0.
- area_q=7, area_r=1, base=3 → D=15; height_q=5, height_r=0. Then area_q=10, area_r=0, base=3 → height_q=6, height_r=2, with range_err=1 when the macro is enabled.
- area_q=1023, area_r=1, base=1 → height_q=2047, height_r=0. Check ready=0 for exactly 11 cycles, done on edge N+11, and range_err=1.
- base=0, area_q=5 → done after 1 cycle; height_q=11'h7FF, height_r=0, div_zero=1.
- Pulse start with new operands mid-DIV → ignored; the original result is produced unchanged. Start held high in DONE → a new operation begins immediately, and done drops for 11 cycles.
- Assert rst at cycle 5 of DIV → IDLE next edge, done=0, outputs 0, ready=1. A following start with area_q=2, area_r=1, base=5 → height_q=1, height_r=0.
